srl_var_delay: RTL and testbench



---
 rtl/srl_var_delay.sv | 158 +++++++++++++++
 tb/tb_srl_var_delay.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/srl_var_delay.sv
// srl_var_delay
// ----------------------------------------------------------------------------
// Runtime-programmable multi-bit delay line with a qualifying valid bit.
// Aligns a data/valid branch with another pipeline branch of different
// latency. The active depth D is loaded at run time (clamped to the physical
// depth). A fill flag reports when the line holds D ce-cycles of history
// since the last flush, load or reset.
//
// Parameters:
//   C_DATA_WIDTH  - width of data_in / data_out (>= 1)
//   C_MAX_DEPTH   - number of physical delay stages (>= 1)
//   C_SEL_WIDTH   - width of depth_sel; must be able to hold C_MAX_DEPTH
//   C_RESET_DEPTH - active depth after reset (0..C_MAX_DEPTH)
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   ce         in   clock enable; advances the delay line and the fill counter
//   flush      in   clears valid pipeline and fill counter (not gated by ce)
//   depth_load in   latches depth_sel as new active depth, implies a flush
//   depth_sel  in   requested depth in ce-cycles (clamped to C_MAX_DEPTH)
//   data_in    in   sample input
//   valid_in   in   qualifies data_in
//   data_out   out  delayed sample
//   valid_out  out  delayed valid
//   primed     out  line holds depth_q ce-cycles of post-flush history
//
// Optional feature macro: SRL_VAR_DELAY_DATA_RESET_EN
//   defined     - data stages clear on rst and on flush/load, and data_out is
//                 forced to 0 whenever valid_out is 0 (D >= 1).
//   not defined - data stages carry no reset so they can map onto shift-
//                 register LUTs; data_out is don't-care while valid_out is 0.
//
// Handshake: there is no backpressure. A sample is taken on every rising
// edge with ce high; valid_in/valid_out only qualify the data, they are not
// a request/acknowledge pair.
// ----------------------------------------------------------------------------
module srl_var_delay #(
  parameter int C_DATA_WIDTH  = 16,
  parameter int C_MAX_DEPTH   = 32,
  parameter int C_SEL_WIDTH   = 6,
  parameter int C_RESET_DEPTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    flush,
  input  logic                    depth_load,
  input  logic [C_SEL_WIDTH-1:0]  depth_sel,
  input  logic [C_DATA_WIDTH-1:0] data_in,
  input  logic                    valid_in,
  output logic [C_DATA_WIDTH-1:0] data_out,
  output logic                    valid_out,
  output logic                    primed
);

  localparam logic [C_SEL_WIDTH-1:0] MAX_D   = C_SEL_WIDTH'(C_MAX_DEPTH);
  localparam logic [C_SEL_WIDTH-1:0] RESET_D = C_SEL_WIDTH'(C_RESET_DEPTH);

  logic [C_DATA_WIDTH-1:0] data_q [C_MAX_DEPTH];
  logic [C_MAX_DEPTH-1:0]  valid_q;
  logic [C_SEL_WIDTH-1:0]  depth_q;
  logic [C_SEL_WIDTH-1:0]  fill_cnt;

  logic [C_DATA_WIDTH-1:0] tap_data;
  logic                    tap_valid;

  // A load always restarts the fill history, so it is folded into flush.
  logic clear_hist;
  assign clear_hist = depth_load | flush;

  // Active depth register; out-of-range requests clamp to the physical depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= RESET_D;
    end else if (depth_load) begin
      depth_q <= (depth_sel > MAX_D) ? MAX_D : depth_sel;
    end
  end

  // Fill counter saturates at depth_q. Because depth_q only changes together
  // with a counter clear, fill_cnt never exceeds depth_q.
  always_ff @(posedge clk) begin
    if (rst || clear_hist) begin
      fill_cnt <= '0;
    end else if (ce && (fill_cnt < depth_q)) begin
      fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // Valid pipeline. A flush/load clears every stage, including the one that
  // would otherwise capture valid_in on that edge.
  always_ff @(posedge clk) begin
    if (rst || clear_hist) begin
      valid_q <= '0;
    end else if (ce) begin
      valid_q[0] <= valid_in;
      for (int i = 1; i < C_MAX_DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Data pipeline.
  always_ff @(posedge clk) begin
`ifdef SRL_VAR_DELAY_DATA_RESET_EN
    if (rst || clear_hist) begin
      for (int i = 0; i < C_MAX_DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else if (ce) begin
      data_q[0] <= data_in;
      for (int i = 1; i < C_MAX_DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end
`else
    // No reset or clear term here so the stages stay a pure shift register.
    if (ce) begin
      data_q[0] <= data_in;
      for (int i = 1; i < C_MAX_DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end
`endif
  end

  // Output tap: stage D-1 for D >= 1.
  always_comb begin
    tap_data  = data_q[0];
    tap_valid = valid_q[0];
    for (int i = 0; i < C_MAX_DEPTH; i++) begin
      if (depth_q == C_SEL_WIDTH'(i + 1)) begin
        tap_data  = data_q[i];
        tap_valid = valid_q[i];
      end
    end
  end

  // D = 0 is a pure combinational bypass; every other depth uses registers.
  always_comb begin
    data_out  = tap_data;
    valid_out = tap_valid;
    if (depth_q == '0) begin
      data_out  = data_in;
      valid_out = valid_in;
    end else begin
`ifdef SRL_VAR_DELAY_DATA_RESET_EN
      // Invalid samples can still shift in with non-zero data, so gate here.
      data_out = tap_valid ? tap_data : '0;
`endif
    end
  end

  // With D = 0 the counter is pinned at 0, so this decode reads 1.
  assign primed = (fill_cnt == depth_q);

endmodule

// File: tb/tb_srl_var_delay.sv
module tb_srl_var_delay;

  localparam int DW   = 16;
  localparam int MAXD = 32;
  localparam int SW   = 6;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b0;
  logic          flush = 1'b0;
  logic          depth_load = 1'b0;
  logic [SW-1:0] depth_sel = '0;
  logic [DW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          primed;

  always #5 clk = ~clk;

  srl_var_delay #(
    .C_DATA_WIDTH (DW),
    .C_MAX_DEPTH  (MAXD),
    .C_SEL_WIDTH  (SW),
    .C_RESET_DEPTH(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .flush     (flush),
    .depth_load(depth_load),
    .depth_sel (depth_sel),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .primed    (primed)
  );

  // ---------------- reference model ----------------
  // History of {valid, data} samples taken by ce edges since the last
  // flush/load/reset, oldest first. Output at depth D is the D-th most recent.
  logic [DW:0] hist[$];
  int          m_d     = 1;
  bit          started = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic model_edge(input bit r, input bit c, input bit f, input bit l,
                            input logic [SW-1:0] s, input bit v, input logic [DW-1:0] d);
    if (r) begin
      hist.delete();
      m_d = 1;
    end else if (l) begin
      hist.delete();
      m_d = (int'(s) > MAXD) ? MAXD : int'(s);
    end else if (f) begin
      hist.delete();
    end else if (c) begin
      hist.push_back({v, d});
      if (hist.size() > MAXD + 8) void'(hist.pop_front());
    end
  endtask

  task automatic check_outputs(input string tag);
    logic          exp_v;
    logic [DW-1:0] exp_dat;
    logic          exp_p;
    logic [DW:0]   e;
    if (m_d == 0) begin
      exp_v   = valid_in;
      exp_dat = data_in;
      exp_p   = 1'b1;
    end else if (hist.size() >= m_d) begin
      e       = hist[hist.size() - m_d];
      exp_v   = e[DW];
      exp_dat = e[DW-1:0];
      exp_p   = 1'b1;
    end else begin
      exp_v   = 1'b0;
      exp_dat = '0;
      exp_p   = 1'b0;
    end

    checks++;
    assert (valid_out === exp_v) else begin
      errors++;
      $error("FAIL %s valid_out: observed %b expected %b (D=%0d)", tag, valid_out, exp_v, m_d);
    end
    checks++;
    assert (primed === exp_p) else begin
      errors++;
      $error("FAIL %s primed: observed %b expected %b (D=%0d)", tag, primed, exp_p, m_d);
    end
    if (exp_v) begin
      checks++;
      assert (data_out === exp_dat) else begin
        errors++;
        $error("FAIL %s data_out: observed %h expected %h (D=%0d)", tag, data_out, exp_dat, m_d);
      end
    end
`ifdef SRL_VAR_DELAY_DATA_RESET_EN
    else if (m_d != 0) begin
      checks++;
      assert (data_out === '0) else begin
        errors++;
        $error("FAIL %s data_out_zero: observed %h expected 0 (D=%0d)", tag, data_out, m_d);
      end
    end
`endif
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge, outputs are checked 1 time unit later
  // (covers the D=0 bypass), and the model advances at the rising edge.
  task automatic step(input string tag, input bit r, input bit c, input bit f, input bit l,
                      input logic [SW-1:0] s, input bit v, input logic [DW-1:0] d);
    @(negedge clk);
    rst        = r;
    ce         = c;
    flush      = f;
    depth_load = l;
    depth_sel  = s;
    valid_in   = v;
    data_in    = d;
    #1;
    if (started) check_outputs(tag);
    @(posedge clk);
    model_edge(r, c, f, l, s, v, d);
    started = 1'b1;
  endtask

  task automatic stream(input string tag, input int n, input int ce_mode);
    // ce_mode: 0 = always high, 1 = alternate, 2 = random
    bit c;
    for (int i = 0; i < n; i++) begin
      case (ce_mode)
        0:       c = 1'b1;
        1:       c = (i % 2) == 0;
        default: c = ($urandom_range(0, 3) != 0);
      endcase
      step(tag, 0, c, 0, 0, '0, ($urandom_range(0, 4) != 0), DW'($urandom));
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    // Reset, with load and flush also high in the last reset cycle.
    step("reset", 1, 0, 0, 0, '0, 0, '0);
    step("reset_ld", 1, 1, 1, 1, 6'd7, 1, 16'hdead);

    // D=1 basic stream 1,2,3.
    step("d1_s1", 0, 1, 0, 0, '0, 1, 16'd1);
    step("d1_s2", 0, 1, 0, 0, '0, 1, 16'd2);
    step("d1_s3", 0, 1, 0, 0, '0, 1, 16'd3);
    stream("d1_rand", 10, 0);

    // Load depth 5 and stream 0x10, 0x11, ...
    step("ld5", 0, 1, 0, 1, 6'd5, 1, 16'h00ff);
    for (int i = 0; i < 12; i++) step("d5_s", 0, 1, 0, 0, '0, 1, DW'(16'h10 + i));

    // D=4 with alternating ce.
    step("ld4", 0, 1, 0, 1, 6'd4, 1, 16'h1234);
    stream("d4_cetog", 24, 1);

    // Out-of-range request clamps to 32.
    step("ld63", 0, 1, 0, 1, 6'd63, 1, 16'h5555);
    stream("d32", 40, 0);

    // D=0 combinational bypass.
    step("ld0", 0, 1, 0, 1, 6'd0, 1, 16'haaaa);
    stream("d0", 12, 2);

    // D=3, mid-stream flush.
    step("ld3", 0, 1, 0, 1, 6'd3, 1, 16'h0f0f);
    stream("d3_pre", 8, 0);
    step("flush", 0, 1, 1, 0, '0, 1, 16'hbeef);
    stream("d3_post", 8, 0);
    stream("d3_rnd", 10, 2);

    // Load and flush together behave as load.
    step("ld_fl", 0, 1, 1, 1, 6'd2, 1, 16'h7777);
    stream("d2", 10, 2);

    // Reset together with load and flush mid-stream.
    step("rst_mid", 1, 1, 1, 1, 6'd9, 1, 16'h4242);
    stream("post_rst", 6, 0);

    // Random mix of all controls.
    for (int i = 0; i < 400; i++) begin
      bit r, f, l;
      r = ($urandom_range(0, 149) == 0);
      l = ($urandom_range(0, 29) == 0);
      f = ($urandom_range(0, 19) == 0);
      step("rand", r, ($urandom_range(0, 3) != 0), f, l, SW'($urandom_range(0, 63)),
           ($urandom_range(0, 4) != 0), DW'($urandom));
    end

    // One final observation after the last edge.
    @(negedge clk);
    #1;
    check_outputs("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
